pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle CPU datapath; supersedes the fixed 13-bit PC register plus external adder/next-PC mux. Computes and registers the next fetch address from an opcode (increment, absolute jump, conditional relative branch, call, return, hold). It includes a hardware return-address stack with full/empty status and sticky error flags. The unit sits between the control unit (op, cond) and instruction memory (pc_out).

---
 rtl/pc_unit_pkg.sv | 20 ++
 rtl/pc_unit_if.sv | 48 ++++
 rtl/pc_unit_ret_stack.sv | 51 +++++
 rtl/pc_unit.sv | 107 ++++++++++
 tb/tb_pc_unit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_pkg
//  Purpose  : Shared constants for the program-counter unit: operation code
//             width and the encodings of each PC operation.
//  Revision : 1.0  initial release
// ============================================================================
package pc_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC  = 3'b000;
    localparam logic [OP_W-1:0] OP_JMP  = 3'b001;
    localparam logic [OP_W-1:0] OP_BR   = 3'b010;
    localparam logic [OP_W-1:0] OP_CALL = 3'b011;
    localparam logic [OP_W-1:0] OP_RET  = 3'b100;
    localparam logic [OP_W-1:0] OP_HOLD = 3'b101;

endpackage
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_if
//  Purpose  : Bundle between the control unit (master) and the PC unit
//             (slave).
//  Ports    : master drives en/op/cond/target/offset/clr_err and observes
//             pc_out/next_pc/ret_top/depth/stack_full/stack_empty/err_ovf/
//             err_unf; slave is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_unit_if #(
    parameter int ADDR_W      = 13,
    parameter int STACK_DEPTH = 4
) ();
    import pc_unit_pkg::*;

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic              en;
    logic [OP_W-1:0]   op;
    logic              cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] offset;
    logic              clr_err;

    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ret_top;
    logic [DEPTH_W-1:0] depth;
    logic              stack_full;
    logic              stack_empty;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output en, op, cond, target, offset, clr_err,
        input  pc_out, next_pc, ret_top, depth, stack_full, stack_empty,
               err_ovf, err_unf
    );

    modport slave (
        input  en, op, cond, target, offset, clr_err,
        output pc_out, next_pc, ret_top, depth, stack_full, stack_empty,
               err_ovf, err_unf
    );

endinterface
`default_nettype wire

// File: rtl/pc_unit_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ret_stack
//  Purpose  : Parametrised LIFO holding return addresses.
//  Ports    : clk, reset (sync, active-high); push/pop requests (ignored
//             when full/empty respectively); din pushed value; dout current
//             top entry (0 when empty); depth occupancy; full/empty status.
//  Revision : 1.0  initial release
// ============================================================================
module ret_stack #(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 4
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic                           push,
    input  wire logic                           pop,
    input  wire logic [DATA_W-1:0]              din,
    output logic      [DATA_W-1:0]              dout,
    output logic      [$clog2(DEPTH+1)-1:0]     depth,
    output logic                                full,
    output logic                                empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // Entry storage is deliberately not reset; only occupancy matters.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DW-1:0]     r_depth;
    logic [DW-1:0]     w_top_idx;

    assign w_top_idx = r_depth - DW'(1);
    assign full      = (r_depth == DW'(DEPTH));
    assign empty     = (r_depth == '0);
    assign depth     = r_depth;
    assign dout      = empty ? '0 : r_mem[w_top_idx[IW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
        end else if (push && !full) begin
            r_mem[r_depth[IW-1:0]] <= din;
            r_depth                <= r_depth + DW'(1);
        end else if (pop && !empty) begin
            r_depth <= r_depth - DW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Registered program counter with next-PC selection (increment,
//             jump, relative branch, call, return, hold), a hardware
//             return-address stack and sticky overflow/underflow flags.
//  Ports    : clk, reset (sync, active-high); bus (pc_unit_if.slave) carrying
//             en/op/cond/target/offset/clr_err in and pc_out/next_pc/ret_top/
//             depth/stack_full/stack_empty/err_ovf/err_unf out.
//  Revision : 1.0  initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int STACK_DEPTH = 4,
    parameter int INC         = 1,
    parameter int RESET_ADDR  = 0
) (
    input  wire logic  clk,
    input  wire logic  reset,
    pc_unit_if.slave   bus
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_err_ovf;
    logic              r_err_unf;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_br;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_ret_top;
    logic              w_full;
    logic              w_empty;
    logic              w_is_call;
    logic              w_is_ret;
    logic              w_push;
    logic              w_pop;

    // Offsets are ADDR_W wide, so modular addition gives the sign-extended
    // displacement relative to the current PC for free.
    assign w_pc_inc = r_pc + ADDR_W'(INC);
    assign w_pc_br  = r_pc + bus.offset;

    assign w_is_call = (bus.op == OP_CALL);
    assign w_is_ret  = (bus.op == OP_RET);

    // A CALL on a full stack or a RET on an empty one degrades to INC.
    assign w_push = bus.en && w_is_call && !w_full;
    assign w_pop  = bus.en && w_is_ret  && !w_empty;

    always_comb begin
        w_next_pc = w_pc_inc;
        unique case (bus.op)
            OP_JMP:  w_next_pc = bus.target;
            OP_BR:   w_next_pc = bus.cond ? w_pc_br : w_pc_inc;
            OP_CALL: w_next_pc = w_full  ? w_pc_inc : bus.target;
            OP_RET:  w_next_pc = w_empty ? w_pc_inc : w_ret_top;
            OP_HOLD: w_next_pc = r_pc;
            default: w_next_pc = w_pc_inc;
        endcase
    end

    ret_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ret_stack (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_pc_inc),
        .dout   (w_ret_top),
        .depth  (bus.depth),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= ADDR_W'(RESET_ADDR);
        end else if (bus.en) begin
            r_pc <= w_next_pc;
        end
    end

    // Clear first, then OR in a new event so a coincident error wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= (r_err_ovf && !bus.clr_err) || (bus.en && w_is_call && w_full);
            r_err_unf <= (r_err_unf && !bus.clr_err) || (bus.en && w_is_ret && w_empty);
        end
    end

    assign bus.pc_out      = r_pc;
    assign bus.next_pc     = w_next_pc;
    assign bus.ret_top     = w_ret_top;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.err_ovf     = r_err_ovf;
    assign bus.err_unf     = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit (ADDR_W=13,
//             STACK_DEPTH=4, INC=1, RESET_ADDR=0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pc_unit_if #(.ADDR_W(13), .STACK_DEPTH(4)) bus ();

    pc_unit #(
        .ADDR_W      (13),
        .STACK_DEPTH (4),
        .INC         (1),
        .RESET_ADDR  (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [12:0] tgt,
                         input logic [12:0] off, input logic cnd,
                         input logic en, input logic clr);
        bus.op      = op;
        bus.target  = tgt;
        bus.offset  = off;
        bus.cond    = cnd;
        bus.en      = en;
        bus.clr_err = clr;
    endtask

    // Apply one operation across one rising edge; outputs sampled 1 ns later.
    task automatic step(input logic [2:0] op, input logic [12:0] tgt,
                        input logic [12:0] off, input logic cnd,
                        input logic en, input logic clr);
        drive(op, tgt, off, cnd, en, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    32'(bus.pc_out),      32'h0);
        chk({tag, "_depth"}, 32'(bus.depth),       32'h0);
        chk({tag, "_empty"}, 32'(bus.stack_empty), 32'h1);
        chk({tag, "_full"},  32'(bus.stack_full),  32'h0);
        chk({tag, "_ovf"},   32'(bus.err_ovf),     32'h0);
        chk({tag, "_unf"},   32'(bus.err_unf),     32'h0);
        chk({tag, "_top"},   32'(bus.ret_top),     32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(OP_JMP, 13'h1555, 13'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset_state("rst");

        reset = 1'b0;
        step(OP_INC, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("inc1", 32'(bus.pc_out), 32'h1);
        step(OP_INC, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("inc2", 32'(bus.pc_out), 32'h2);
        step(OP_INC, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("inc3", 32'(bus.pc_out), 32'h3);
        chk("inc3_empty", 32'(bus.stack_empty), 32'h1);
        chk("inc3_ovf",   32'(bus.err_ovf),     32'h0);
        chk("inc3_unf",   32'(bus.err_unf),     32'h0);

        // Relative branch, negative offset, taken and not taken
        step(OP_JMP, 13'h010, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("jmp10", 32'(bus.pc_out), 32'h010);
        step(OP_BR, 13'h0, 13'h1FFC, 1'b1, 1'b1, 1'b0);
        chk("br_taken", 32'(bus.pc_out), 32'h00C);
        step(OP_JMP, 13'h010, 13'h0, 1'b0, 1'b1, 1'b0);
        step(OP_BR, 13'h0, 13'h1FFC, 1'b0, 1'b1, 1'b0);
        chk("br_not", 32'(bus.pc_out), 32'h011);

        // Wrap and stall
        step(OP_JMP, 13'h1FFF, 13'h0, 1'b0, 1'b1, 1'b0);
        step(OP_INC, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("wrap", 32'(bus.pc_out), 32'h0000);
        drive(OP_JMP, 13'h0ABC, 13'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_next", 32'(bus.next_pc), 32'h0ABC);
        step(OP_JMP, 13'h0ABC, 13'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_pc", 32'(bus.pc_out), 32'h0000);
        step(OP_JMP, 13'h0ABC, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("jmp_abc", 32'(bus.pc_out), 32'h0ABC);
        step(OP_HOLD, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("hold", 32'(bus.pc_out), 32'h0ABC);

        // Nested call / return
        step(OP_JMP, 13'h020, 13'h0, 1'b0, 1'b1, 1'b0);
        step(OP_CALL, 13'h100, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("call1_pc", 32'(bus.pc_out), 32'h100);
        chk("call1_d",  32'(bus.depth),  32'h1);
        chk("call1_top", 32'(bus.ret_top), 32'h021);
        step(OP_CALL, 13'h200, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("call2_pc", 32'(bus.pc_out), 32'h200);
        chk("call2_d",  32'(bus.depth),  32'h2);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("ret1_pc", 32'(bus.pc_out), 32'h101);
        chk("ret1_d",  32'(bus.depth),  32'h1);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("ret2_pc", 32'(bus.pc_out), 32'h021);
        chk("ret2_d",  32'(bus.depth),  32'h0);
        chk("ret2_empty", 32'(bus.stack_empty), 32'h1);

        // Fill the stack, then overflow
        step(OP_CALL, 13'h400, 13'h0, 1'b0, 1'b1, 1'b0);
        step(OP_CALL, 13'h500, 13'h0, 1'b0, 1'b1, 1'b0);
        step(OP_CALL, 13'h600, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("fill3_full", 32'(bus.stack_full), 32'h0);
        step(OP_CALL, 13'h300, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("fill4_pc",   32'(bus.pc_out),     32'h300);
        chk("fill4_full", 32'(bus.stack_full), 32'h1);
        chk("fill4_d",    32'(bus.depth),      32'h4);
        step(OP_CALL, 13'h700, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("ovf_pc",  32'(bus.pc_out),  32'h301);
        chk("ovf_d",   32'(bus.depth),   32'h4);
        chk("ovf_flag", 32'(bus.err_ovf), 32'h1);
        chk("ovf_top", 32'(bus.ret_top), 32'h601);
        step(OP_HOLD, 13'h0, 13'h0, 1'b0, 1'b1, 1'b1);
        chk("ovf_clr", 32'(bus.err_ovf), 32'h0);
        chk("ovf_clr_pc", 32'(bus.pc_out), 32'h301);

        // Drain in LIFO order
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("drain1", 32'(bus.pc_out), 32'h601);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("drain2", 32'(bus.pc_out), 32'h501);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("drain3", 32'(bus.pc_out), 32'h401);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("drain4", 32'(bus.pc_out), 32'h022);
        chk("drain4_empty", 32'(bus.stack_empty), 32'h1);

        // Underflow, and clear coinciding with a fresh underflow
        step(OP_JMP, 13'h050, 13'h0, 1'b0, 1'b1, 1'b0);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("unf_pc",   32'(bus.pc_out),  32'h051);
        chk("unf_flag", 32'(bus.err_unf), 32'h1);
        step(OP_RET, 13'h0, 13'h0, 1'b0, 1'b1, 1'b1);
        chk("unf_clr_same", 32'(bus.err_unf), 32'h1);
        chk("unf_clr_pc",   32'(bus.pc_out),  32'h052);

        // Reset mid-sequence overrides en/op
        step(OP_CALL, 13'h123, 13'h0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_d", 32'(bus.depth), 32'h1);
        reset = 1'b1;
        step(OP_CALL, 13'h0456, 13'h0, 1'b0, 1'b1, 1'b0);
        chk_reset_state("midrst");
        reset = 1'b0;

        // Reserved opcode behaves as INC
        step(3'b111, 13'h0777, 13'h0, 1'b1, 1'b1, 1'b0);
        chk("rsvd", 32'(bus.pc_out), 32'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
